// File: rtl/axil_pkg.sv
// AXI4-Lite response codes and shared elaboration helpers for the SRAM bank.
// No logic and no latency.
// No flow control.
package axil_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    // Ceiling log2 used to size index and byte-offset fields at elaboration.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_sram_bank_if.sv
// AXI4-Lite bus bundle: AW, W, B, AR and R channels with master/slave views.
// No logic and no latency.
// Standard valid/ready on every channel.
interface axil_sram_bank_if
    import axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    axi_resp_t           bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    axi_resp_t           rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_lat_cnt.sv
// Load/countdown timer: o_done is high in the cycle before the i_bound-th edge after i_start.
// A flop set from o_done therefore rises exactly i_bound edges after the start edge.
// No backpressure; a new i_start reloads the count and abandons the previous one.
module axil_lat_cnt (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_bound,
    output logic       o_done
);
    logic [7:0] cnt;

    // Load on start, then count down to zero and park there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 8'd0;
        end else if (i_start) begin
            cnt <= i_bound;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign o_done = (cnt == 8'd1);
endmodule

// File: rtl/axil_sram_bank.sv
// AXI4-Lite slave over an on-chip byte-lane memory with decode errors outside the window.
// R valid RD_LAT edges after AR accept; B valid WR_LAT edges after the write commit edge.
// One write and one read in flight; readys are pure state and drop while buffers/busy are set.
module axil_sram_bank
    import axil_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int              RD_LAT    = 1,
    parameter int              WR_LAT    = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    axil_sram_bank_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * NB);

    // Window check: below BASE_ADDR wraps the offset, so both bounds are tested.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    // Byte offset bits are dropped, so unaligned addresses hit the containing word.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE_ADDR) >> clog2(NB);
        return IDX_W'(off);
    endfunction

    logic              rst_done;
    logic              aw_full, w_full, wr_wait, rd_busy;
    logic              bvalid_q, rvalid_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q, rdata_q, rd_word;
    logic [NB-1:0]     w_strb_q;
    axi_resp_t         bresp_q, rresp_q;
    logic              awready_w, wready_w, arready_w;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic              commit, wr_done, rd_done;
    logic              wr_hit, rd_hit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    assign awready_w = rst_done && !aw_full;
    assign wready_w  = rst_done && !w_full;
    assign arready_w = rst_done && !rd_busy;

    assign aw_hs = bus.awvalid && awready_w;
    assign w_hs  = bus.wvalid  && wready_w;
    assign ar_hs = bus.arvalid && arready_w;
    assign b_hs  = bvalid_q && bus.bready;
    assign r_hs  = rvalid_q && bus.rready;

    // A B handshake on this edge frees the write path, so back-to-back commits are allowed.
    assign commit = aw_full && w_full && !(wr_wait || (bvalid_q && !bus.bready));

    assign wr_hit = addr_hit(aw_addr_q);
    assign wr_idx = word_idx(aw_addr_q);
    assign rd_hit = addr_hit(bus.araddr);
    assign rd_idx = word_idx(bus.araddr);

    // No ready is offered until one full cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // AW and W holding buffers fill independently and empty together on commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_full   <= 1'b1;
                aw_addr_q <= bus.awaddr;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full   <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end
        end
    end

    // Write response: wait out the latency after commit, then hold B until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_wait  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= AXI_RESP_OKAY;
        end else begin
            if (commit) begin
                wr_wait <= 1'b1;
                bresp_q <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            end else if (wr_done) begin
                wr_wait <= 1'b0;
            end
            if (wr_done)   bvalid_q <= 1'b1;
            else if (b_hs) bvalid_q <= 1'b0;
        end
    end

    // Read: sample the array on AR accept, so a same-edge commit is not yet visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_busy  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= AXI_RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rd_busy <= 1'b1;
                rdata_q <= rd_hit ? rd_word : '0;
                rresp_q <= rd_hit ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            end else if (r_hs) begin
                rd_busy <= 1'b0;
            end
            if (rd_done)   rvalid_q <= 1'b1;
            else if (r_hs) rvalid_q <= 1'b0;
        end
    end

    axil_lat_cnt u_rd_lat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (ar_hs),
        .i_bound (8'(RD_LAT)),
        .o_done  (rd_done)
    );

    axil_lat_cnt u_wr_lat (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (commit),
        .i_bound (8'(WR_LAT)),
        .o_done  (wr_done)
    );

    // One array per byte lane keeps strobed writes free of read-modify-write.
    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [7:0] lane [DEPTH];

        // Strobed byte write on the commit edge; contents are intentionally not reset.
        always_ff @(posedge i_clk) begin
            if (commit && wr_hit && w_strb_q[b]) begin
                lane[wr_idx] <= w_data_q[8*b +: 8];
            end
        end

        assign rd_word[8*b +: 8] = lane[rd_idx];
    end

    assign bus.awready = awready_w;
    assign bus.wready  = wready_w;
    assign bus.arready = arready_w;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;
endmodule

// File: tb/tb_axil_sram_bank.sv
// Directed bench: table of write/read vectors on a RD_LAT=WR_LAT=1 bank,
// plus hand sequences for W-before-AW, latency/backpressure (RD_LAT=4, WR_LAT=3),
// read-before-write collision and reset mid-transaction.
module tb_axil_sram_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_sram_bank_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    axil_sram_bank_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    axil_sram_bank #(.RD_LAT(1), .WR_LAT(1)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b0)
    );

    axil_sram_bank #(.RD_LAT(4), .WR_LAT(3)) u_dut_lat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b1)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        b0.awaddr = '0; b0.awvalid = 0; b0.wdata = '0; b0.wstrb = '0; b0.wvalid = 0;
        b0.bready = 0;  b0.araddr = '0; b0.arvalid = 0; b0.rready = 0;
        b1.awaddr = '0; b1.awvalid = 0; b1.wdata = '0; b1.wstrb = '0; b1.wvalid = 0;
        b1.bready = 0;  b1.araddr = '0; b1.arvalid = 0; b1.rready = 0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_ok, w_ok, aw_hs, w_hs;
        int cyc;
        aw_ok = 0; w_ok = 0; cyc = 0;
        b0.awaddr = addr; b0.awvalid = 1;
        b0.wdata = data; b0.wstrb = strb; b0.wvalid = 1;
        while (!(aw_ok && w_ok) && cyc < 20) begin
            aw_hs = b0.awvalid && b0.awready;
            w_hs  = b0.wvalid && b0.wready;
            tick();
            cyc++;
            if (aw_hs) begin aw_ok = 1; b0.awvalid = 0; end
            if (w_hs)  begin w_ok = 1;  b0.wvalid = 0;  end
        end
        b0.awvalid = 0; b0.wvalid = 0;
        resp = 2'bxx;
        if (!(aw_ok && w_ok)) begin
            timeout("write aw/w");
            return;
        end
        b0.bready = 1;
        cyc = 0;
        while (!b0.bvalid && cyc < 300) begin tick(); cyc++; end
        if (!b0.bvalid) begin
            timeout("write b");
            b0.bready = 0;
            return;
        end
        resp = b0.bresp;
        tick();
        b0.bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int cyc;
        cyc = 0;
        data = 'x; resp = 'x; lat = -1;
        b0.araddr = addr; b0.arvalid = 1;
        while (!b0.arready && cyc < 20) begin tick(); cyc++; end
        if (!b0.arready) begin
            timeout("read ar");
            b0.arvalid = 0;
            return;
        end
        tick();
        b0.arvalid = 0;
        lat = 0;
        while (!b0.rvalid && lat < 300) begin tick(); lat++; end
        data = b0.rdata;
        resp = b0.rresp;
        b0.rready = 1;
        tick();
        b0.rready = 0;
    endtask

    function automatic logic [41:0] outs0();
        return {b0.awready, b0.wready, b0.bvalid, b0.bresp, b0.arready,
                b0.rvalid, b0.rresp, b0.rdata};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0]  resp;
        logic [31:0] data;
        int          lat, cnt;

        idle_bus();

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};
        vecs[4]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 2'b11, 32'h0};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[8]  = '{1'b0, 32'h8000_1000, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[9]  = '{1'b1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h8000_0FFE, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        vecs[11] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44};

        // Reset state and rst_done gating of ready.
        #3;
        check("reset outputs", 32'(outs0()), 32'h0);
        check("reset outputs hi", 32'(outs0() >> 32), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("ready before rst_done", 32'({b0.awready, b0.wready, b0.arready}), 32'h0);
        tick();
        check("ready after rst_done", 32'({b0.awready, b0.wready, b0.arready}), 32'h7);

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, data, resp, lat);
                check($sformatf("vec%0d rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d rdata", i), data, vecs[i].exp_rdata);
                check($sformatf("vec%0d rd latency", i), 32'(lat), 32'd1);
            end
        end

        // W three cycles ahead of AW.
        b0.wdata = 32'h0BAD_C0DE; b0.wstrb = 4'hF; b0.wvalid = 1;
        tick();
        b0.wvalid = 0;
        check("w-first wready dropped", 32'(b0.wready), 32'h0);
        tick(); tick();
        check("w-first no early b", 32'(b0.bvalid), 32'h0);
        check("w-first awready", 32'(b0.awready), 32'h1);
        b0.awaddr = 32'h8000_0020; b0.awvalid = 1;
        tick();
        b0.awvalid = 0;
        b0.bready = 1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (b0.bvalid) begin
                cnt++;
                check("w-first bresp", 32'(b0.bresp), 32'h0);
            end
            tick();
        end
        b0.bready = 0;
        check("w-first b count", 32'(cnt), 32'd1);
        check("w-first wready back", 32'(b0.wready), 32'h1);
        axi_read(32'h8000_0020, data, resp, lat);
        check("w-first readback", data, 32'h0BAD_C0DE);

        // Latency and backpressure on the RD_LAT=4 / WR_LAT=3 bank.
        b1.awaddr = 32'h8000_0040; b1.awvalid = 1;
        b1.wdata = 32'h5555_AAAA; b1.wstrb = 4'hF; b1.wvalid = 1;
        tick();
        b1.awvalid = 0; b1.wvalid = 0;
        lat = 0;
        while (!b1.bvalid && lat < 50) begin tick(); lat++; end
        // Commit is one edge after capture, then WR_LAT edges to bvalid.
        check("lat b ticks", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            check("lat bvalid held", 32'(b1.bvalid), 32'h1);
            check("lat bresp held", 32'(b1.bresp), 32'h0);
            tick();
        end
        b1.bready = 1;
        tick();
        b1.bready = 0;
        check("lat bvalid cleared", 32'(b1.bvalid), 32'h0);

        b1.araddr = 32'h8000_0040; b1.arvalid = 1;
        check("lat arready idle", 32'(b1.arready), 32'h1);
        tick();
        b1.arvalid = 0;
        lat = 0;
        while (!b1.rvalid && lat < 50) begin
            check("lat arready busy", 32'(b1.arready), 32'h0);
            tick();
            lat++;
        end
        check("lat r ticks", 32'(lat), 32'd4);
        for (int c = 0; c < 5; c++) begin
            check("lat rvalid held", 32'(b1.rvalid), 32'h1);
            check("lat rdata held", b1.rdata, 32'h5555_AAAA);
            check("lat rresp held", 32'(b1.rresp), 32'h0);
            check("lat arready held low", 32'(b1.arready), 32'h0);
            tick();
        end
        b1.rready = 1;
        tick();
        b1.rready = 0;
        check("lat rvalid cleared", 32'(b1.rvalid), 32'h0);
        check("lat arready returns", 32'(b1.arready), 32'h1);

        // Same-word collision: AR accepted on the commit edge sees old data.
        axi_write(32'h8000_0030, 32'h1111_1111, 4'hF, resp);
        check("coll preload bresp", 32'(resp), 32'h0);
        b0.awaddr = 32'h8000_0030; b0.awvalid = 1;
        b0.wdata = 32'h2222_2222; b0.wstrb = 4'hF; b0.wvalid = 1;
        tick();
        b0.awvalid = 0; b0.wvalid = 0;
        b0.araddr = 32'h8000_0030; b0.arvalid = 1;
        tick();
        b0.arvalid = 0;
        tick();
        check("coll rvalid", 32'(b0.rvalid), 32'h1);
        check("coll old data", b0.rdata, 32'h1111_1111);
        check("coll bvalid same cycle", 32'(b0.bvalid), 32'h1);
        b0.bready = 1;
        tick();
        b0.bready = 0;
        // Park an address in the AW buffer so a stale commit after reset would show.
        b0.awaddr = 32'h8000_0030; b0.awvalid = 1;
        tick();
        b0.awvalid = 0;
        check("coll rvalid pending", 32'(b0.rvalid), 32'h1);

        // Reset with rvalid pending.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset outputs", 32'(outs0()), 32'h0);
        check("midreset outputs hi", 32'(outs0() >> 32), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (b0.bvalid || b0.rvalid) cnt++;
            tick();
        end
        check("no response after reset", 32'(cnt), 32'd0);
        b0.wdata = 32'h3333_3333; b0.wstrb = 4'hF; b0.wvalid = 1;
        tick();
        b0.wvalid = 0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (b0.bvalid) cnt++;
            tick();
        end
        check("no stale commit b", 32'(cnt), 32'd0);
        axi_read(32'h8000_0030, data, resp, lat);
        check("post-reset readback", data, 32'h2222_2222);
        check("post-reset rresp", 32'(resp), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
